// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: sample FIFO feeding a Philips-I2S serializer.
// SCLK/LRCLK are divided down from CLK and only ever leave as data outputs.
// The single mono sample in the hold register is sent in both the left and
// right slots. A new sample is popped at the start of every left slot.
module i2s_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int SCLK_DIV = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FIFO_WRITE,
    input  logic [23:0]                AUDIO_IN,
    output logic                       FIFO_FULL,
    output logic [$clog2(DEPTH):0]     FIFO_LEVEL,
    output logic                       SCLK,
    output logic                       LRCLK,
    output logic                       SDATA,
    output logic                       UNDERRUN
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_TC = CW'(SCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [23:0]   hold_q, hold_d;
    logic [CW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          und_q, und_d;
    logic [5:0]    idx_q, idx_d;

    logic          tc, fall, pop, do_wr, do_rd;
    logic [5:0]    idx_nx;
    logic [4:0]    slot_b, bit_sel;

    // Divider, frame sequencing, FIFO bookkeeping and serializer next state.
    always_comb begin
        tc      = (div_q == DIV_TC);
        fall    = tc && sclk_q;
        idx_nx  = idx_q + 6'd1;
        pop     = fall && (idx_nx == 6'd0);
        // Full is judged on registered level, so a pop in the same cycle
        // does not make room for a write.
        do_wr   = FIFO_WRITE && (level_q != LVL_FULL);
        do_rd   = pop && (level_q != '0);
        slot_b  = idx_nx[4:0];
        bit_sel = 5'd24 - slot_b;

        div_d   = tc ? '0 : div_q + CW'(1);
        sclk_d  = tc ? ~sclk_q : sclk_q;
        idx_d   = idx_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        hold_d  = hold_q;
        und_d   = pop && (level_q == '0);
        wptr_d  = do_wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_rd ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(do_wr) - LW'(do_rd);

        if (do_rd)
            hold_d = mem_q[rptr_q];
        if (fall) begin
            idx_d   = idx_nx;
            lrclk_d = idx_nx[5];
            // Slot bit 0 is the one-bit I2S delay; bits 25..31 pad with zero.
            // At slot bit 0 the hold register may be changing, but it is not read.
            if (slot_b >= 5'd1 && slot_b <= 5'd24)
                sdata_d = hold_q[bit_sel];
            else
                sdata_d = 1'b0;
        end
    end

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge CLK) begin
        if (do_wr)
            mem_q[wptr_q] <= AUDIO_IN;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            hold_q  <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            und_q   <= 1'b0;
            idx_q   <= 6'd63;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            und_q   <= und_d;
            idx_q   <= idx_d;
        end
    end

    assign FIFO_FULL  = (level_q == LVL_FULL);
    assign FIFO_LEVEL = level_q;
    assign SCLK       = sclk_q;
    assign LRCLK      = lrclk_q;
    assign SDATA      = sdata_q;
    assign UNDERRUN   = und_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: a per-cycle reference model derived from frame
// arithmetic (time since reset -> bit index) and a sample queue, plus
// directed checks on decoded frames.
module tb_i2s_tx_fifo;

    localparam int DEPTH = 16;
    localparam int D     = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          FIFO_WRITE = 1'b0;
    logic [23:0]   AUDIO_IN = '0;
    logic          FIFO_FULL;
    logic [LW-1:0] FIFO_LEVEL;
    logic          SCLK, LRCLK, SDATA, UNDERRUN;

    i2s_tx_fifo #(.DEPTH(DEPTH), .SCLK_DIV(D)) dut (
        .CLK(CLK), .RESET(RESET), .FIFO_WRITE(FIFO_WRITE), .AUDIO_IN(AUDIO_IN),
        .FIFO_FULL(FIFO_FULL), .FIFO_LEVEL(FIFO_LEVEL), .SCLK(SCLK),
        .LRCLK(LRCLK), .SDATA(SDATA), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // model state
    int          t;
    int          midx;
    logic [23:0] mq[$];
    logic [23:0] mhold;
    logic        e_sclk, e_lr, e_sd, e_und;
    // frame capture from DUT pins
    int          rises;
    logic        prev_sclk;
    logic [63:0] sr;
    logic [63:0] frames[$];
    int          und_cnt;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
        end
    endtask

    function automatic logic [63:0] fexp(input logic [23:0] s);
        return {1'b0, s, 7'b0, 1'b0, s, 7'b0};
    endfunction

    task automatic tick(input logic rst, input logic wr, input logic [23:0] d);
        int pre, b;
        logic [LW-1:0] elev;
        RESET = rst; FIFO_WRITE = wr; AUDIO_IN = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            t = 0; midx = 63; mq.delete(); mhold = '0;
            e_sclk = 0; e_lr = 0; e_sd = 0; e_und = 0;
            rises = 0; prev_sclk = 0; sr = '0; frames.delete(); und_cnt = 0;
        end else begin
            t++;
            pre = mq.size();
            e_und = 0;
            e_sclk = ((t / D) % 2) == 1;
            if (t % (2 * D) == 0) begin
                midx = (midx + 1) % 64;
                if (midx == 0) begin
                    if (pre > 0) mhold = mq.pop_front();
                    else e_und = 1;
                end
                b = midx % 32;
                e_sd = (b >= 1 && b <= 24) ? mhold[24 - b] : 1'b0;
                e_lr = (midx >= 32);
            end
            if (wr && pre < DEPTH) mq.push_back(d);
        end
        elev = LW'(mq.size());
        check("outs", 64'({SCLK, LRCLK, SDATA, UNDERRUN, FIFO_FULL, FIFO_LEVEL}),
              64'({e_sclk, e_lr, e_sd, e_und, (mq.size() == DEPTH), elev}));
        if (!rst) begin
            if (UNDERRUN) und_cnt++;
            if (SCLK && !prev_sclk) begin
                rises++;
                sr = {sr[62:0], SDATA};
                if (rises >= 65 && (rises - 65) % 64 == 0) frames.push_back(sr);
            end
            prev_sclk = SCLK;
        end
    endtask

    task automatic do_reset(input int n, input logic wr);
        for (int i = 0; i < n; i++) tick(1'b1, wr, 24'h5A5A5A);
    endtask

    task automatic idle_until(input int tt);
        int g = 0;
        while (t < tt && g < 20000) begin tick(0, 0, 0); g++; end
    endtask

    task automatic run_frames(input int n);
        int g = 0;
        while (frames.size() < n && g < 20000) begin tick(0, 0, 0); g++; end
        check("frames_timeout", 64'(frames.size() >= n), 64'(1));
    endtask

    // Checks release timing: first rise at D, first fall at 2D with an underrun.
    task automatic check_startup(input string tag);
        int g = 0;
        while (!SCLK && g < 100) begin tick(0, 0, 0); g++; end
        check({tag, "_rise_t"}, 64'(t), 64'(D));
        g = 0;
        while (SCLK && g < 100) begin tick(0, 0, 0); g++; end
        check({tag, "_fall_t"}, 64'(t), 64'(2 * D));
        check({tag, "_first_pop_und"}, 64'(UNDERRUN), 64'(1));
    endtask

    initial begin
        logic [23:0] s17[17];
        logic [23:0] abc[3];

        // reset with write held high
        do_reset(3, 1'b1);
        check("rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("rst_full", 64'(FIFO_FULL), 64'(0));
        check("rst_pins", 64'({SCLK, LRCLK, SDATA, UNDERRUN}), 64'(0));
        check_startup("pwr");

        // serialization of one sample, left and right slots
        do_reset(1, 1'b0);
        tick(0, 1, 24'hABCDEF);
        run_frames(1);
        check("ser_frame", frames[0], fexp(24'hABCDEF));

        // underrun repeats the last sample, one pulse
        do_reset(1, 1'b0);
        tick(0, 1, 24'h800001);
        run_frames(2);
        check("rep_f0", frames[0], fexp(24'h800001));
        check("rep_f1", frames[1], fexp(24'h800001));
        check("rep_und_cnt", 64'(und_cnt), 64'(1));

        // full / drop
        do_reset(1, 1'b0);
        idle_until(2 * D + 1);
        for (int i = 0; i < 17; i++) begin
            s17[i] = 24'h010101 * 24'(i + 1) + 24'h000100;
            tick(0, 1, s17[i]);
            if (i == 15) check("full_after16", 64'(FIFO_FULL), 64'(1));
        end
        check("full_level", 64'(FIFO_LEVEL), 64'(16));
        run_frames(18);
        for (int i = 1; i <= 16; i++) check("full_order", frames[i], fexp(s17[i-1]));
        check("full_no17", frames[17], fexp(s17[15]));

        // write on pop cycle with level 3
        do_reset(1, 1'b0);
        idle_until(2 * D + 1);
        abc[0] = 24'h111111; abc[1] = 24'h222222; abc[2] = 24'h333333;
        for (int i = 0; i < 3; i++) tick(0, 1, abc[i]);
        idle_until(130 * D - 1);
        tick(0, 1, 24'h444444);
        check("sim_level3", 64'(FIFO_LEVEL), 64'(3));
        check("sim_no_und", 64'(UNDERRUN), 64'(0));
        run_frames(5);
        check("sim_f1", frames[1], fexp(24'h111111));
        check("sim_f2", frames[2], fexp(24'h222222));
        check("sim_f3", frames[3], fexp(24'h333333));
        check("sim_f4", frames[4], fexp(24'h444444));

        // write on pop cycle with empty FIFO
        do_reset(1, 1'b0);
        idle_until(2 * D - 1);
        tick(0, 1, 24'h0F0F0F);
        check("sim0_und", 64'(UNDERRUN), 64'(1));
        check("sim0_level", 64'(FIFO_LEVEL), 64'(1));

        // mid-frame reset at index 40 with level 5
        do_reset(1, 1'b0);
        idle_until(2 * D + 1);
        for (int i = 0; i < 5; i++) tick(0, 1, 24'(32'h00C0DE + i));
        begin
            int g = 0;
            while (midx != 40 && g < 20000) begin tick(0, 0, 0); g++; end
        end
        check("mid_level5", 64'(FIFO_LEVEL), 64'(5));
        tick(1, 0, 0);
        check("mid_rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("mid_rst_pins", 64'({SCLK, LRCLK, SDATA, UNDERRUN, FIFO_FULL}), 64'(0));
        check_startup("mid");

        // randomized traffic: fill phase then drain into underrun
        do_reset(1, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            if (i < 2000 && $urandom_range(0, 99) < 2)
                tick(0, 1, 24'($urandom));
            else
                tick(0, 0, 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Downstream consumer of the synth sample stream. Buffers 24-bit mono samples written with FIFO_WRITE and applies back-pressure through FIFO_FULL. Generates SCLK/LRCLK from CLK by division, with no second clock domain. Serializes each sample as standard Philips I2S, duplicated into the left and right slots, for the codec DAC.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
SCLK_DIV, 8, CLK cycles per SCLK half-period; minimum 1. Frame = 128*SCLK_DIV CLK cycles, so fs = 48.8 kHz at 50 MHz.

Ports:
CLK  in  1  system clock; all logic on posedge.
RESET  in  1  synchronous, active-high reset.
FIFO_WRITE  in  1  write strobe, one sample per high cycle.
AUDIO_IN  in  24  signed sample, two's complement.
FIFO_FULL  out  1  high when level == DEPTH.
FIFO_LEVEL  out  $clog2(DEPTH)+1  current occupancy.
SCLK  out  1  I2S bit clock.
LRCLK  out  1  word select; 0 = left, 1 = right.
SDATA  out  1  serial data, MSB first.
UNDERRUN  out  1  one-CLK pulse when a pop finds the FIFO empty.

Behaviour:
- Reset (any cycle, including mid-frame):
  - SCLK=0, LRCLK=0, SDATA=0, UNDERRUN=0.
  - FIFO emptied: level=0, pointers=0, FIFO_FULL=0.
  - Hold register=0. Divider count=0. Frame bit index=63.
- Divider:
  - Counts 0..SCLK_DIV-1. On terminal count, SCLK toggles and the count wraps to 0.
  - A "fall event" is the CLK cycle in which SCLK is driven 1->0.
- Frame index (0..63) advances only on a fall event, wrapping 63->0. On the same edge:
  - LRCLK <= new index[5].
  - SDATA <= bit for the new index.
  - The DAC samples on SCLK rise.
- Slot bit mapping, where b = index[4:0]:
  - b=0 drives 0 (I2S one-bit delay after the LRCLK edge).
  - b=1..24 drive hold[24-b], i.e. MSB first.
  - b=25..31 drive 0.
  - Left and right slots carry the same hold value.
- Pop: occurs on the fall event where the index wraps 63->0 (left-slot start).
  - If level>0: hold <= head, read pointer++, level--.
  - If level==0: hold unchanged (last sample repeats), UNDERRUN=1 for that CLK cycle.
  - The first fall event after reset is a pop.
- Write: when FIFO_WRITE && !FIFO_FULL, AUDIO_IN is stored at the write pointer, write pointer++, level++.
  - A write while FIFO_FULL=1 is dropped, even if a pop occurs in the same cycle.
  - Write and pop in the same cycle with 0<level<DEPTH: level unchanged.
  - Write and pop in the same cycle with level==0: underrun pulses, the write is stored, level=1.
- Pointers wrap modulo DEPTH.
- FIFO_FULL and FIFO_LEVEL come from registered state only; no combinational path from FIFO_WRITE.
- SCLK and LRCLK are registered outputs and are never used as clocks internally.

Test Plan:
- Reset values: assert RESET 3 cycles with FIFO_WRITE=1 -> FIFO_LEVEL=0, FIFO_FULL=0, SCLK=LRCLK=SDATA=0. After release, first SCLK rise at cycle SCLK_DIV and first fall at cycle 2*SCLK_DIV. The first pop pulses UNDERRUN.
- Serialization: write 24'hABCDEF before the first fall event -> the left slot shows 0, then 1010 1011 1100 1101 1110 1111, then 7 zeros. The right slot (LRCLK=1) is identical. The frame spans 128*SCLK_DIV CLK cycles.
- Underrun/repeat: write 24'h800001 once, then nothing -> frame 1 carries 800001. Frame 2 repeats 800001 with UNDERRUN pulsing exactly once, at the left-slot-start fall event.
- Full/drop: write 17 distinct samples back-to-back with DEPTH=16 -> FIFO_FULL=1 after the 16th, the 17th is dropped, and FIFO_LEVEL=16. Over the next 16 frames the outputs are samples 1..16 in order and the 17th never appears.
- Simultaneous write and pop: level=3, FIFO_WRITE on the pop cycle -> level stays 3 and order is preserved. Level=0, write on the pop cycle -> UNDERRUN pulses and level=1.
- Mid-frame reset: RESET at frame index 40 with level=5 -> all outputs return to reset values next cycle, level=0, and the following frame timing restarts exactly as after the power-up reset.
